seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It latches a 32-bit hex value plus a decimal-point mask and cycles through the digits one at a time. For each digit it selects the matching nibble, decodes it to segments through a hex-to-segment sub-module, and drives one anode. It sits between the CPU's display I/O register and the board pins, replacing per-digit static wiring.

---
 rtl/seg_scan_ctrl_pkg.sv | 32 +++
 rtl/seg_scan_ctrl_hex7seg_decode.sv | 19 +
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared definitions for the 7-segment scan controller:
//             digit count, segment bit positions, glyph table, seg_t type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  // Segment bit positions inside seg_t (active-high).
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [7:0] seg_t;

  // Glyphs 0-9, A, b, C, d, E, F; entry n sits at index n. dp bit is always 0.
  localparam logic [15:0][7:0] GLYPHS = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_scan_ctrl_hex7seg_decode.sv
`default_nettype none
// ============================================================================
//  Module   : hex7seg_decode
//  Purpose  : Combinational hex nibble to 7-segment glyph decoder.
//  Ports    : i_nib  [3:0]  hex nibble
//             o_seg  seg_t  segments a..g (bit0..6), dp (bit7) always 0
//  Revision : 1.0  initial release
// ============================================================================
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  assign o_seg = GLYPHS[i_nib];

endmodule : hex7seg_decode
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for an 8-digit common-anode
//             7-segment display. Latches a 32-bit hex value and dp mask,
//             double-buffers them so a frame is never torn, and walks the
//             digits one slot at a time with a short anti-ghost blank.
//  Ports    : clk           system clock, rising edge
//             rst           asynchronous, active-low reset
//             en_i          scan enable (0 = hold position, display dark)
//             load_i        one-cycle strobe capturing data_i / dp_i
//             data_i [31:0] hex value, nibble k on digit k (0 = rightmost)
//             dp_i   [7:0]  decimal-point mask
//             an_o   [7:0]  anode enables, active-low
//             seg_o  [7:0]  segments a..g, dp (active-high)
//             frame_done_o  pulse when the digit index wraps 7 -> 0
//  Params   : PERIOD  cycles per digit slot (>= 2)
//             BLANK   dark cycles at slot start (0 <= BLANK < PERIOD)
//  Config   : SEG_LZ_BLANK_EN  enables leading-zero suppression
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int PERIOD = 100000,
  parameter int BLANK  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  output logic [7:0]  an_o,
  output logic [7:0]  seg_o,
  output logic        frame_done_o
);

  localparam int            CW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] c_last  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] c_blank = CW'(BLANK);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_pend_data;
  logic [7:0]    r_pend_dp;
  logic [31:0]   r_shd_data;
  logic [7:0]    r_shd_dp;

  logic          w_tick;
  logic          w_frame_end;
  logic [3:0]    w_nib;
  seg_t          w_glyph;
  seg_t          w_seg_lit;
  logic [7:0]    w_an_sel;
  logic          w_in_blank;
  logic          w_suppress;

  assign w_tick      = en_i && (r_cnt == c_last);
  assign w_frame_end = w_tick && (r_idx == 3'(NUM_DIGITS - 1));
  assign w_nib       = r_shd_data[{r_idx, 2'b00} +: 4];
  assign w_an_sel    = ~(8'h01 << r_idx);
  assign w_in_blank  = (r_cnt < c_blank);
  assign w_seg_lit   = w_glyph | (8'(r_shd_dp[r_idx]) << SEG_DP);

  hex7seg_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

`ifdef SEG_LZ_BLANK_EN
  // w_zero_from[k] is set when nibbles k..7 of the shadow are all zero.
  logic [7:0] w_zero_from;
  logic       w_acc;

  always_comb begin
    w_zero_from = '0;
    w_acc       = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_acc          = w_acc && (r_shd_data[4*k +: 4] == 4'h0);
      w_zero_from[k] = w_acc;
    end
  end

  // Digit 0 always shows, so a value of zero still reads "0".
  assign w_suppress = (r_idx != 3'd0) && w_zero_from[r_idx];
`else
  assign w_suppress = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_shd_data   <= '0;
      r_shd_dp     <= '0;
      an_o         <= 8'hFF;
      seg_o        <= 8'h00;
      frame_done_o <= 1'b0;
    end else begin
      if (load_i) begin
        r_pend_data <= data_i;
        r_pend_dp   <= dp_i;
      end

      // Shadow changes only between frames; a load landing on the
      // boundary itself is forwarded so it is not delayed a whole frame.
      if (w_frame_end) begin
        r_shd_data <= load_i ? data_i : r_pend_data;
        r_shd_dp   <= load_i ? dp_i   : r_pend_dp;
      end

      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else if (en_i) begin
        r_cnt <= r_cnt + 1'b1;
      end

      frame_done_o <= w_frame_end;

      if (!en_i || w_in_blank) begin
        an_o  <= 8'hFF;
        seg_o <= 8'h00;
      end else if (w_suppress) begin
        // Suppressed digit keeps its dp visible if requested.
        an_o  <= r_shd_dp[r_idx] ? w_an_sel : 8'hFF;
        seg_o <= r_shd_dp[r_idx] ? 8'h80 : 8'h00;
      end else begin
        an_o  <= w_an_sel;
        seg_o <= w_seg_lit;
      end
    end
  end

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Directed self-checking bench for seg_scan_ctrl with PERIOD=4,
//             BLANK=1. Covers reset, scan order, tear-free update, boundary
//             bypass, enable freeze, leading-zero handling (SEG_LZ_BLANK_EN)
//             and asynchronous reset mid-scan.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic        load_i;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [7:0]  an_o;
  logic [7:0]  seg_o;
  logic        frame_done_o;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan_ctrl #(.PERIOD(4), .BLANK(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .load_i       (load_i),
    .data_i       (data_i),
    .dp_i         (dp_i),
    .an_o         (an_o),
    .seg_o        (seg_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run until a frame_done pulse is observed (bounded).
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (frame_done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_wait", 32'(seen), 32'd1);
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] p);
    load_i = 1'b1;
    data_i = d;
    dp_i   = p;
    step(1);
    load_i = 1'b0;
  endtask

  // Expected per-digit values, worked out by hand from the glyph table.
  logic [7:0] scan_seg [8] = '{8'hF1, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F};
`ifdef SEG_LZ_BLANK_EN
  logic [7:0] lz_seg [8] = '{8'h6D, 8'h3F, 8'h77, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00};
  logic [7:0] lz_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
`else
  logic [7:0] lz_seg [8] = '{8'h6D, 8'h3F, 8'h77, 8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'h3F};
  logic [7:0] lz_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
`endif
  logic [7:0] an_walk [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  initial begin
    int n;
    rst    = 1'b0;
    en_i   = 1'b1;
    load_i = 1'b0;
    data_i = '0;
    dp_i   = '0;

    // Reset
    step(3);
    check("rst_an", 32'(an_o), 32'hFF);
    check("rst_seg", 32'(seg_o), 32'h00);
    check("rst_fd", 32'(frame_done_o), 32'd0);
    rst = 1'b1;
    step(1);
    check("first_blank_an", 32'(an_o), 32'hFF);
    step(1);
    check("d0_an", 32'(an_o), 32'hFE);
    check("d0_seg", 32'(seg_o), 32'h3F);
    step(2);
    check("d0_an_end", 32'(an_o), 32'hFE);
    step(1);
    check("slot1_blank", 32'(an_o), 32'hFF);

    // Frame period
    wait_frame();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      n++;
      if (i == 0) check("fd_width", 32'(frame_done_o), 32'd0);
      if (frame_done_o) break;
    end
    check("frame_period", 32'(n), 32'd32);

    // Scan order
    load(32'h89ABCDEF, 8'h01);
    wait_frame();
    step(2);
    for (int d = 0; d < 8; d++) begin
      check($sformatf("scan_an%0d", d), 32'(an_o), 32'(an_walk[d]));
      check($sformatf("scan_seg%0d", d), 32'(seg_o), 32'(scan_seg[d]));
      step(4);
    end

    // Tear-free update: load while idx=3
    wait_frame();
    step(12);
    load(32'h11111111, 8'h00);
    step(1);
    for (int d = 3; d < 8; d++) begin
      check($sformatf("tear_seg%0d", d), 32'(seg_o), 32'(scan_seg[d]));
      if (d < 7) step(4);
    end
    wait_frame();
    step(2);
    check("tear_new_d0", 32'(seg_o), 32'h06);
    step(4);
    check("tear_new_d1", 32'(seg_o), 32'h06);

    // Coincident load at frame boundary
    wait_frame();
    step(31);
    load(32'h12345678, 8'h00);
    check("bypass_fd", 32'(frame_done_o), 32'd1);
    step(2);
    check("bypass_d0", 32'(seg_o), 32'h7F);
    step(4);
    check("bypass_d1_an", 32'(an_o), 32'hFD);
    check("bypass_d1", 32'(seg_o), 32'h07);

    // Enable freeze: state now idx1 cnt2
    en_i = 1'b0;
    step(1);
    check("dis_an", 32'(an_o), 32'hFF);
    check("dis_seg", 32'(seg_o), 32'h00);
    step(3);
    check("dis_an_hold", 32'(an_o), 32'hFF);
    en_i = 1'b1;
    step(1);
    check("res_an_a", 32'(an_o), 32'hFD);
    check("res_seg_a", 32'(seg_o), 32'h07);
    step(1);
    check("res_an_b", 32'(an_o), 32'hFD);
    step(1);
    check("res_blank", 32'(an_o), 32'hFF);
    step(1);
    check("res_d2_an", 32'(an_o), 32'hFB);
    check("res_d2_seg", 32'(seg_o), 32'h7D);

    // Leading zeros
    load(32'h00000A05, 8'h10);
    wait_frame();
    step(2);
    for (int d = 0; d < 8; d++) begin
      check($sformatf("lz_an%0d", d), 32'(an_o), 32'(lz_an[d]));
      check($sformatf("lz_seg%0d", d), 32'(seg_o), 32'(lz_seg[d]));
      step(4);
    end

    // Asynchronous reset mid-scan drops pending data
    load(32'h55555555, 8'h00);
    check("pre_rst_an", 32'(an_o), 32'hFE);
    #2;
    rst = 1'b0;
    #1;
    check("async_an", 32'(an_o), 32'hFF);
    check("async_seg", 32'(seg_o), 32'h00);
    step(1);
    rst = 1'b1;
    step(2);
    check("post_rst_d0", 32'(seg_o), 32'h3F);
    wait_frame();
    step(2);
    check("pend_lost_an", 32'(an_o), 32'hFE);
    check("pend_lost_seg", 32'(seg_o), 32'h3F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
